// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: loads, stores, LL/SC over a req/ack data bus
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic        LLbit_i,
    input  logic        wb_LLbit_we_i,
    input  logic        wb_LLbit_value_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        LLbit_we_o,
    output logic        LLbit_value_o,
    output logic        stallreq_o,
    output logic        exc_adel_o,
    output logic        exc_ades_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0] rdata_q;

    logic op_lb, op_lbu, op_lh, op_lhu, op_lw, op_sb, op_sh, op_sw, op_ll, op_sc;
    logic size_byte, size_half, size_word;
    logic is_load, is_store, misaligned, llbit_eff, sc_fail, access_req;
    logic [3:0]  sel_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign op_lb  = (mem_op_i == 4'd1);
    assign op_lbu = (mem_op_i == 4'd2);
    assign op_lh  = (mem_op_i == 4'd3);
    assign op_lhu = (mem_op_i == 4'd4);
    assign op_lw  = (mem_op_i == 4'd5);
    assign op_sb  = (mem_op_i == 4'd6);
    assign op_sh  = (mem_op_i == 4'd7);
    assign op_sw  = (mem_op_i == 4'd8);
    assign op_ll  = (mem_op_i == 4'd9);
    assign op_sc  = (mem_op_i == 4'd10);

    assign size_byte = op_lb | op_lbu | op_sb;
    assign size_half = op_lh | op_lhu | op_sh;
    assign size_word = op_lw | op_sw | op_ll | op_sc;
    assign is_load   = op_lb | op_lbu | op_lh | op_lhu | op_lw | op_ll;
    assign is_store  = op_sb | op_sh | op_sw | op_sc;

    assign misaligned = (size_half & mem_addr_i[0]) | (size_word & (mem_addr_i[1:0] != 2'b00));
    // A WB-stage LLbit write this cycle is newer than the LLbit register output
    assign llbit_eff  = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
    assign sc_fail    = op_sc & ~llbit_eff;
    assign access_req = (is_load | is_store) & ~misaligned & ~sc_fail;

    // Byte-lane select and replicated store data for the pending access
    always_comb begin
        sel_nxt   = 4'b0000;
        wdata_nxt = reg2_i;
        if (size_byte) begin
            sel_nxt   = 4'b1000 >> mem_addr_i[1:0];
            wdata_nxt = {4{reg2_i[7:0]}};
        end else if (size_half) begin
            sel_nxt   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            wdata_nxt = {2{reg2_i[15:0]}};
        end else if (size_word) begin
            sel_nxt   = 4'b1111;
        end
    end

    // Extract the addressed lane from the captured read data (big-endian)
    always_comb begin
        load_byte = rdata_q[31:24];
        case (mem_addr_i[1:0])
            2'b00:   load_byte = rdata_q[31:24];
            2'b01:   load_byte = rdata_q[23:16];
            2'b10:   load_byte = rdata_q[15:8];
            default: load_byte = rdata_q[7:0];
        endcase
        load_half = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
        load_data = rdata_q;
        if (op_lb)
            load_data = {{24{load_byte[7]}}, load_byte};
        else if (op_lbu)
            load_data = {24'h0, load_byte};
        else if (op_lh)
            load_data = {{16{load_half[15]}}, load_half};
        else if (op_lhu)
            load_data = {16'h0, load_half};
    end

    // State register; flush aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else if (flush)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (access_req) state_nxt = S_BUSY;
            S_BUSY:  if (bus_ack_i) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs: loaded when the access starts, held through BUSY, cleared on ack
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'b0000;
            bus_addr_o  <= 32'h0;
            bus_wdata_o <= 32'h0;
        end else if (state == S_IDLE && access_req) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store;
            bus_sel_o   <= sel_nxt;
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_wdata_o <= is_store ? wdata_nxt : 32'h0;
        end else if (state == S_BUSY && bus_ack_i) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'b0000;
            bus_addr_o  <= 32'h0;
            bus_wdata_o <= 32'h0;
        end
    end

    // Capture read data on the acknowledge
    always_ff @(posedge clk) begin
        if (rst || flush)
            rdata_q <= 32'h0;
        else if (state == S_BUSY && bus_ack_i)
            rdata_q <= bus_rdata_i;
    end

    // Pipeline-side outputs; SC success is decided in IDLE only, once launched it completes as a store
    always_comb begin
        wd_o          = wd_i;
        wreg_o        = wreg_i;
        wdata_o       = wdata_i;
        LLbit_we_o    = 1'b0;
        LLbit_value_o = 1'b0;
        stallreq_o    = 1'b0;
        exc_adel_o    = 1'b0;
        exc_ades_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if ((is_load | is_store) && misaligned) begin
                    wreg_o     = 1'b0;
                    exc_adel_o = is_load;
                    exc_ades_o = is_store;
                end else if (sc_fail) begin
                    wdata_o = 32'h0;
                end else if (access_req) begin
                    stallreq_o = 1'b1;
                end
            end
            S_BUSY: stallreq_o = 1'b1;
            S_DONE: begin
                if (is_load)
                    wdata_o = load_data;
                if (op_ll) begin
                    LLbit_we_o    = 1'b1;
                    LLbit_value_o = 1'b1;
                end
                if (op_sc) begin
                    wdata_o       = 32'h1;
                    LLbit_we_o    = 1'b1;
                    LLbit_value_o = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized model-checked bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i, reg2_i, wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i, LLbit_i, wb_LLbit_we_i, wb_LLbit_value_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        LLbit_we_o, LLbit_value_o, stallreq_o, exc_adel_o, exc_ades_o;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .LLbit_i(LLbit_i), .wb_LLbit_we_i(wb_LLbit_we_i), .wb_LLbit_value_i(wb_LLbit_value_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .LLbit_we_o(LLbit_we_o), .LLbit_value_o(LLbit_value_o),
        .stallreq_o(stallreq_o), .exc_adel_o(exc_adel_o), .exc_ades_o(exc_ades_o)
    );

    int checks = 0;
    int errors = 0;

    logic        chk_en = 1'b0;
    logic        e_stall, e_req, e_we, e_wreg, e_chk_wdata, e_llwe, e_llval, e_adel, e_ades;
    logic [3:0]  e_sel;
    logic [4:0]  e_wd;
    logic [31:0] e_addr, e_bwdata, e_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules, written from the ISA semantics
    function automatic int m_kind(input int op);
        if ((op >= 1 && op <= 5) || op == 9) return 1;
        if ((op >= 6 && op <= 8) || op == 10) return 2;
        return 0;
    endfunction

    function automatic logic m_fault(input int op, input logic [31:0] a);
        if ((op == 3 || op == 4 || op == 7) && (a % 2 != 0)) return 1'b1;
        if ((op == 5 || op == 8 || op == 9 || op == 10) && (a % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_sel(input int op, input logic [31:0] a);
        int lane = int'(a % 4);
        if (op == 1 || op == 2 || op == 6) return 4'b1000 >> lane;
        if (op == 3 || op == 4 || op == 7) return (lane < 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_bwdata(input int op, input logic [31:0] d);
        if (op == 6) return (d & 32'hFF) * 32'h01010101;
        if (op == 7) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int op, input logic [31:0] a, input logic [31:0] rd);
        int lane = int'(a % 4);
        logic [31:0] v;
        if (op == 1 || op == 2) begin
            v = (rd >> (8 * (3 - lane))) & 32'hFF;
            if (op == 1 && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (op == 3 || op == 4) begin
            v = (rd >> ((lane < 2) ? 16 : 0)) & 32'hFFFF;
            if (op == 3 && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Compare process: every enabled cycle, all outputs against the expectation
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stallreq_o", stallreq_o, e_stall);
            chk("bus_req_o", bus_req_o, e_req);
            chk("bus_we_o", bus_we_o, e_we);
            chk("bus_sel_o", bus_sel_o, e_sel);
            chk("bus_addr_o", bus_addr_o, e_addr);
            chk("bus_wdata_o", bus_wdata_o, e_bwdata);
            chk("wd_o", wd_o, e_wd);
            chk("wreg_o", wreg_o, e_wreg);
            if (e_chk_wdata) chk("wdata_o", wdata_o, e_wdata);
            chk("LLbit_we_o", LLbit_we_o, e_llwe);
            if (e_llwe) chk("LLbit_value_o", LLbit_value_o, e_llval);
            chk("exc_adel_o", exc_adel_o, e_adel);
            chk("exc_ades_o", exc_ades_o, e_ades);
        end
    end

    task automatic exp_quiet();
        e_stall = 0; e_req = 0; e_we = 0; e_sel = 4'h0; e_addr = 32'h0; e_bwdata = 32'h0;
        e_wd = wd_i; e_wreg = wreg_i; e_chk_wdata = 1; e_wdata = wdata_i;
        e_llwe = 0; e_llval = 0; e_adel = 0; e_ades = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        mem_op_i = 4'd0; flush = 0; rst = 0;
        wd_i = 5'($urandom); wreg_i = 1'($urandom); wdata_i = $urandom;
        bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
        exp_quiet();
        next_cycle();
    endtask

    // abort: 0 none, 1 flush in first BUSY cycle, 2 rst in first BUSY cycle
    task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] d2,
                          input logic ll_i, input logic wbwe, input logic wbval,
                          input int wait_n, input logic [31:0] rdata, input int abort,
                          input logic lit_en, input logic [31:0] lit_wdata, input logic [3:0] lit_sel);
        logic eff, flt, scf;
        int   kind;
        mem_op_i = 4'(op); mem_addr_i = addr; reg2_i = d2;
        LLbit_i = ll_i; wb_LLbit_we_i = wbwe; wb_LLbit_value_i = wbval;
        wd_i = 5'($urandom); wreg_i = 1'($urandom); wdata_i = $urandom;
        flush = 0; rst = 0;
        eff  = wbwe ? wbval : ll_i;
        kind = m_kind(op);
        flt  = (kind != 0) && m_fault(op, addr);
        scf  = (op == 10) && !flt && !eff;
        exp_quiet();
        bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
        if (kind == 0 || flt || scf) begin
            if (flt) begin
                e_wreg = 0; e_chk_wdata = 0; e_adel = (kind == 1); e_ades = (kind == 2);
            end
            if (scf) e_wdata = 32'h0;
            @(negedge clk); #1;
            if (lit_en) chk("lit_wdata", wdata_o, lit_wdata);
            next_cycle();
            return;
        end
        e_stall = 1; e_chk_wdata = 0;
        next_cycle();
        for (int c = 1; c <= wait_n + 1; c++) begin
            e_stall = 1; e_req = 1; e_we = (kind == 2); e_sel = m_sel(op, addr);
            e_addr = addr & 32'hFFFFFFFC; e_bwdata = (kind == 2) ? m_bwdata(op, d2) : 32'h0;
            bus_ack_i = (c == wait_n + 1) && (abort == 0);
            bus_rdata_i = bus_ack_i ? rdata : $urandom;
            if (abort == 1 && c == 1) flush = 1;
            if (abort == 2 && c == 1) rst = 1;
            @(negedge clk); #1;
            if (lit_sel != 4'h0 && c == 1) chk("lit_sel", bus_sel_o, lit_sel);
            next_cycle();
            if (abort != 0) begin
                flush = 0; rst = 0; mem_op_i = 4'd0; bus_ack_i = 1;
                exp_quiet();
                next_cycle();
                idle_cycle();
                return;
            end
        end
        exp_quiet();
        bus_ack_i = 1'($urandom); bus_rdata_i = $urandom;
        if (kind == 1) e_wdata = m_load(op, addr, rdata); else e_chk_wdata = 0;
        if (op == 9) begin e_llwe = 1; e_llval = 1; end
        if (op == 10) begin e_chk_wdata = 1; e_wdata = 32'h1; e_llwe = 1; e_llval = 0; end
        @(negedge clk); #1;
        if (lit_en) chk("lit_wdata", wdata_o, lit_wdata);
        next_cycle();
    endtask

    initial begin
        int op, wt;
        logic [31:0] a;
        rst = 1; flush = 0; mem_op_i = 0; mem_addr_i = 0; reg2_i = 0;
        wd_i = 0; wreg_i = 0; wdata_i = 0; LLbit_i = 0; wb_LLbit_we_i = 0; wb_LLbit_value_i = 0;
        bus_rdata_i = 0; bus_ack_i = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        exp_quiet();
        chk_en = 1;
        idle_cycle();
        idle_cycle();

        run_op(5, 32'h100, 32'h0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 4'hF);
        run_op(1, 32'h103, 32'h0, 0, 0, 0, 1, 32'h000000F0, 0, 1, 32'hFFFFFFF0, 4'h1);
        run_op(2, 32'h103, 32'h0, 0, 0, 0, 0, 32'h000000F0, 0, 1, 32'h000000F0, 4'h1);
        run_op(3, 32'h102, 32'h0, 0, 0, 0, 2, 32'h1234ABCD, 0, 1, 32'hFFFFABCD, 4'h3);
        run_op(7, 32'h102, 32'h1234ABCD, 0, 0, 0, 4, 32'h0, 0, 0, 32'h0, 4'h3);
        run_op(9, 32'h200, 32'h0, 0, 0, 0, 0, 32'h55AA00FF, 0, 1, 32'h55AA00FF, 4'hF);
        run_op(10, 32'h200, 32'h87654321, 0, 1, 1, 1, 32'h0, 0, 1, 32'h1, 4'hF);
        run_op(10, 32'h200, 32'h87654321, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 4'h0);
        run_op(10, 32'h204, 32'h87654321, 1, 1, 0, 0, 32'h0, 0, 1, 32'h0, 4'h0);
        run_op(5, 32'h101, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0);
        run_op(7, 32'h101, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0);
        run_op(5, 32'h300, 32'h0, 0, 0, 0, 6, 32'h0, 1, 0, 32'h0, 4'hF);
        run_op(8, 32'h304, 32'hCAFEF00D, 0, 0, 0, 6, 32'h0, 2, 0, 32'h0, 4'hF);

        for (int i = 0; i < 250; i++) begin
            op = int'($urandom_range(0, 15));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (op == 3 || op == 4 || op == 7) ? {a[1], 1'b0} : 2'b00;
            if (op == 1 || op == 2 || op == 6) a = $urandom;
            wt = int'($urandom_range(0, 3));
            run_op(op, a, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), wt, $urandom,
                   ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0, 0, 32'h0, 4'h0);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
